// File: rtl/reg_file_sb.sv
// Integer register file with async clear, optional write-to-read bypass and pending-write scoreboard.
// Latency: reads and hazard outputs are combinational; writes and scoreboard marks land on the rising edge.
// Backpressure: stall asks decode to hold; while stalled, issue marks (sb_set) are dropped.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 5,
  parameter int REG_NUM  = 32,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] rs1,
  input  logic [ADDR_LEN-1:0] rs2,
  input  logic                rs1_use,
  input  logic                rs2_use,
  input  logic [ADDR_LEN-1:0] rd,
  input  logic [XLEN-1:0]     rd_d,
  input  logic                reg_wr,
  input  logic                sb_set,
  input  logic [ADDR_LEN-1:0] sb_rd,
  output logic [XLEN-1:0]     rs1_d,
  output logic [XLEN-1:0]     rs2_d,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                stall,
  output logic [CNT_W-1:0]    sb_cnt
);

  // x0 is hardwired, so storage and pending bits start at index 1.
  logic [XLEN-1:0]    regs [1:REG_NUM-1];
  logic [REG_NUM-1:1] pend;
  logic [REG_NUM-1:1] pend_nxt;

  logic [XLEN-1:0] raw1, raw2;
  logic            p1, p2, psb, prd;
  logic            wr_ok, byp1, byp2, byp_sb;
  logic            waw, set_ok, inc, dec;

  // Address names an implemented register other than x0.
  function automatic logic in_rng(input logic [ADDR_LEN-1:0] a);
    return (a != '0) && (32'(a) < 32'(REG_NUM));
  endfunction

  function automatic logic hit(input logic [ADDR_LEN-1:0] a, input int i);
    return 32'(a) == 32'(i);
  endfunction

  // A write only counts out of reset and to a real register; this also suppresses the bypass in reset.
  assign wr_ok  = rst_n & reg_wr & in_rng(rd);
  assign byp1   = (BYPASS != 0) && wr_ok && (rd == rs1);
  assign byp2   = (BYPASS != 0) && wr_ok && (rd == rs2);
  assign byp_sb = (BYPASS != 0) && wr_ok && (rd == sb_rd);

  // Decode all lookups by scanning implemented registers; unmatched addresses read as 0 / not pending.
  always_comb begin
    raw1 = '0;
    raw2 = '0;
    p1   = 1'b0;
    p2   = 1'b0;
    psb  = 1'b0;
    prd  = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (hit(rs1, i)) begin
        raw1 = regs[i];
        p1   = pend[i];
      end
      if (hit(rs2, i)) begin
        raw2 = regs[i];
        p2   = pend[i];
      end
      if (hit(sb_rd, i)) psb = pend[i];
      if (hit(rd, i))    prd = pend[i];
    end
  end

  // A write that clears a register this cycle also hides its busy flag when forwarding is enabled.
  assign rs1_d    = byp1 ? rd_d : raw1;
  assign rs2_d    = byp2 ? rd_d : raw2;
  assign rs1_busy = p1 & ~byp1;
  assign rs2_busy = p2 & ~byp2;
  assign waw      = sb_set & psb & ~byp_sb;
  assign stall    = (rs1_use & rs1_busy) | (rs2_use & rs2_busy) | waw;

  // Counter moves by at most one: a set of an idle register, or a clear not overridden by a set.
  assign set_ok = rst_n & sb_set & ~stall & in_rng(sb_rd);
  assign inc    = set_ok & ~psb;
  assign dec    = wr_ok & prd & ~(set_ok && (sb_rd == rd));

  // Next pending vector: set wins over a same-cycle clear of the same register.
  always_comb begin
    pend_nxt = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      pend_nxt[i] = (set_ok && hit(sb_rd, i)) | (pend[i] & ~(wr_ok && hit(rd, i)));
    end
  end

  // Register storage: cleared by reset, written from the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (wr_ok && hit(rd, i)) regs[i] <= rd_d;
      end
    end
  end

  // Scoreboard state and its popcount, kept in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      sb_cnt <= '0;
    end else begin
      pend   <= pend_nxt;
      sb_cnt <= sb_cnt + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule
